// File: rtl/arith_initiator.sv
// Initiator side of the start/busy handshake for iterative arithmetic units.
// It latches the operands, pulses start, follows busy through one operation and returns the result or a timeout error.
module arith_initiator #(
    parameter int A_W     = 32,
    parameter int B_W     = 32,
    parameter int Y_W     = 64,
    parameter int TIMEOUT = 64
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           req_valid_i,
    output logic           req_ready_o,
    input  logic [A_W-1:0] a_bi,
    input  logic [B_W-1:0] b_bi,
    output logic           start_o,
    output logic [A_W-1:0] a_bo,
    output logic [B_W-1:0] b_bo,
    input  logic           busy_i,
    input  logic [Y_W-1:0] y_bi,
    output logic           rsp_valid_o,
    input  logic           rsp_ready_i,
    output logic [Y_W-1:0] y_bo,
    output logic           err_o
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        RESP
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t         state, state_nxt;
    logic [15:0]    cnt, cnt_nxt, cnt_inc;
    logic           start_nxt, rsp_valid_nxt, err_nxt;
    logic [Y_W-1:0] y_nxt;
    logic [A_W-1:0] a_nxt;
    logic [B_W-1:0] b_nxt;
    logic           accept;

    // A unit still busy for another master must not be handed a new start
    assign req_ready_o = (state == IDLE) && !busy_i;
    assign accept      = req_valid_i && req_ready_o;
    assign cnt_inc     = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            cnt         <= 16'd0;
            start_o     <= 1'b0;
            rsp_valid_o <= 1'b0;
            err_o       <= 1'b0;
            y_bo        <= '0;
            a_bo        <= '0;
            b_bo        <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            start_o     <= start_nxt;
            rsp_valid_o <= rsp_valid_nxt;
            err_o       <= err_nxt;
            y_bo        <= y_nxt;
            a_bo        <= a_nxt;
            b_bo        <= b_nxt;
        end
    end

    // Registered outputs are computed one state ahead so start_o and rsp_valid_o line up with their states
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        start_nxt     = 1'b0;
        rsp_valid_nxt = 1'b0;
        err_nxt       = err_o;
        y_nxt         = y_bo;
        a_nxt         = a_bo;
        b_nxt         = b_bo;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    a_nxt     = a_bi;
                    b_nxt     = b_bi;
                    start_nxt = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                cnt_nxt   = 16'd0;
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (busy_i) begin
                    cnt_nxt   = 16'd0;
                    state_nxt = WAIT_DONE;
                end else if (cnt == CNT_LAST) begin
                    err_nxt       = 1'b1;
                    y_nxt         = '0;
                    rsp_valid_nxt = 1'b1;
                    state_nxt     = RESP;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            WAIT_DONE: begin
                if (!busy_i) begin
                    err_nxt       = 1'b0;
                    y_nxt         = y_bi;
                    rsp_valid_nxt = 1'b1;
                    state_nxt     = RESP;
                end else if (cnt == CNT_LAST) begin
                    err_nxt       = 1'b1;
                    y_nxt         = '0;
                    rsp_valid_nxt = 1'b1;
                    state_nxt     = RESP;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_nxt = IDLE;
                end else begin
                    rsp_valid_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_arith_initiator.sv
// Scoreboard bench for arith_initiator: a behavioural unit model with programmable start delay and busy length
// answers start pulses, while a monitor checks every response against values queued when the request was issued.
module tb_arith_initiator;

    localparam int TIMEOUT = 16;
    localparam logic [63:0] JUNK = 64'hDEAD_BEEF_0BAD_F00D;

    typedef struct {
        int d;
        int l;
    } unit_cfg_t;

    typedef struct {
        logic [63:0] y;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [31:0] a_bi = '0;
    logic [31:0] b_bi = '0;
    logic        start_o;
    logic [31:0] a_bo;
    logic [31:0] b_bo;
    logic        busy_i = 1'b0;
    logic [63:0] y_bi = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b1;
    logic [63:0] y_bo;
    logic        err_o;

    int checks = 0;
    int errors = 0;
    int accepted = 0;
    int starts = 0;
    int last_wait = 0;
    int u_state = 0;
    int u_dly = 0;
    int u_rem = 0;
    int u_len = 0;
    logic [63:0] u_prod = '0;
    logic start_prev = 1'b0;
    bit rand_rdy = 1'b0;

    unit_cfg_t unit_q[$];
    exp_t      exp_q[$];

    arith_initiator #(
        .A_W(32),
        .B_W(32),
        .Y_W(64),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .a_bi(a_bi),
        .b_bi(b_bi),
        .start_o(start_o),
        .a_bo(a_bo),
        .b_bo(b_bo),
        .busy_i(busy_i),
        .y_bi(y_bi),
        .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i),
        .y_bo(y_bo),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Unit model: d < 0 never goes busy, otherwise busy rises d cycles late and stays up for l cycles
    always @(posedge clk) begin
        unit_cfg_t cfg;
        case (u_state)
            0: begin
                if (start_o) begin
                    if (unit_q.size() == 0) begin
                        check_output("start_without_job", 64'(unit_q.size()), 64'd1);
                    end else begin
                        cfg    = unit_q.pop_front();
                        u_prod = 64'(a_bo) * 64'(b_bo);
                        u_len  = cfg.l;
                        if (cfg.d == 0) begin
                            busy_i  <= 1'b1;
                            y_bi    <= JUNK;
                            u_rem   = cfg.l;
                            u_state = 2;
                        end else if (cfg.d > 0) begin
                            u_dly   = cfg.d;
                            u_state = 1;
                        end
                    end
                end
            end
            1: begin
                u_dly--;
                if (u_dly == 0) begin
                    busy_i  <= 1'b1;
                    y_bi    <= JUNK;
                    u_rem   = u_len;
                    u_state = 2;
                end
            end
            default: begin
                u_rem--;
                if (u_rem == 0) begin
                    busy_i  <= 1'b0;
                    y_bi    <= u_prod;
                    u_state = 0;
                end
            end
        endcase
    end

    // Monitor: pops the scoreboard on every response handshake and polices start pulse width
    always @(negedge clk) begin
        exp_t e;
        if (rst_i && rsp_valid_o && rsp_ready_i) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_rsp_queue_size", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                check_output("rsp_y", y_bo, e.y);
                check_output("rsp_err", 64'(err_o), 64'(e.err));
            end
        end
        if (start_o) begin
            starts++;
            check_output("start_prev_low", 64'(start_prev), 64'd0);
        end
        start_prev = start_o;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) rsp_ready_i = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL global_timeout: got no finish expected finish");
        $fatal(1, "[TB] simulation did not terminate");
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input int d, input int l,
                         input bit expect_rsp, input bit wait_unit, output int waited);
        unit_cfg_t c;
        exp_t      e;
        int        k;
        if (wait_unit) begin
            k = 0;
            while (u_state != 0 && k < 1000) begin
                @(posedge clk);
                #1;
                k++;
            end
            if (k >= 1000) check_output("unit_idle_timeout", 64'(k), 64'd0);
        end
        c.d = d;
        c.l = l;
        unit_q.push_back(c);
        if (expect_rsp) begin
            e.err = (d < 0) || (d >= TIMEOUT) || (l > TIMEOUT);
            e.y   = e.err ? 64'd0 : 64'(a) * 64'(b);
            exp_q.push_back(e);
        end
        req_valid_i = 1'b1;
        a_bi        = a;
        b_bi        = b;
        waited      = 0;
        while (waited < 1000) begin
            @(negedge clk);
            if (req_ready_o) break;
            waited++;
        end
        if (waited >= 1000) check_output("req_accept_timeout", 64'(waited), 64'd0);
        @(posedge clk);
        #1;
        accepted++;
        req_valid_i = 1'b0;
        a_bi        = $urandom;
        b_bi        = $urandom;
    endtask

    // Directed request: checks start timing, response latency and optional backpressure hold
    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b, input int d, input int l,
                                  input int hold, input bit wait_unit);
        int lat;
        int exp_lat;
        int w;
        logic exp_err;
        logic [63:0] exp_y;
        exp_err = (d < 0) || (d >= TIMEOUT) || (l > TIMEOUT);
        exp_y   = exp_err ? 64'd0 : 64'(a) * 64'(b);
        if (d < 0 || d >= TIMEOUT) exp_lat = TIMEOUT + 2;
        else if (l > TIMEOUT)      exp_lat = d + TIMEOUT + 3;
        else                       exp_lat = d + l + 3;
        if (hold > 0) rsp_ready_i = 1'b0;
        issue(a, b, d, l, 1'b1, wait_unit, w);
        last_wait = w;
        lat = 0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (lat == 1) check_output("start_cycle1", 64'(start_o), 64'd1);
            if (lat == 2) check_output("start_cycle2_low", 64'(start_o), 64'd0);
            if (rsp_valid_o) break;
        end
        check_output("rsp_latency", 64'(lat), 64'(exp_lat));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_output("bp_valid", 64'(rsp_valid_o), 64'd1);
            check_output("bp_y", y_bo, exp_y);
            check_output("bp_err", 64'(err_o), 64'(exp_err));
            check_output("bp_req_ready", 64'(req_ready_o), 64'd0);
        end
        if (hold > 0) begin
            @(posedge clk);
            #1;
            rsp_ready_i = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  w;
        int  k;
        bit  saw;
        $display("[TB] starting arith_initiator bench");
        #2;
        rst_i = 1'b0;
        repeat (2) @(negedge clk);
        check_output("reset_start", 64'(start_o), 64'd0);
        check_output("reset_rsp_valid", 64'(rsp_valid_o), 64'd0);
        check_output("reset_err", 64'(err_o), 64'd0);
        check_output("reset_y", y_bo, 64'd0);
        check_output("reset_a", 64'(a_bo), 64'd0);
        check_output("reset_b", 64'(b_bo), 64'd0);
        check_output("reset_req_ready", 64'(req_ready_o), 64'd1);
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        @(negedge clk);
        check_output("idle_req_ready", 64'(req_ready_o), 64'd1);
        @(posedge clk);
        #1;

        apply_stimulus(32'd25, 32'd7, 0, 8, 0, 1'b1);
        apply_stimulus(32'd10, 32'd20, 0, 3, 5, 1'b1);
        apply_stimulus(32'd100, 32'd3, 0, 1, 0, 1'b1);
        apply_stimulus(32'd255, 32'd255, 0, 16, 0, 1'b1);
        apply_stimulus(32'd2, 32'd3, 0, 17, 0, 1'b1);
        apply_stimulus(32'd9, 32'd9, 15, 2, 0, 1'b1);
        apply_stimulus(32'd4, 32'd4, 16, 2, 0, 1'b1);
        apply_stimulus(32'd7, 32'd7, -1, 1, 0, 1'b1);
        apply_stimulus(32'd6, 32'd6, 0, 60, 0, 1'b1);
        apply_stimulus(32'd11, 32'd13, 0, 2, 0, 1'b0);
        check_output("blocked_while_busy", 64'(last_wait >= 35), 64'd1);

        // Reset in WAIT_DONE: no response may come out for the aborted request
        issue(32'd50, 32'd2, 0, 30, 1'b0, 1'b1, w);
        repeat (6) @(negedge clk);
        rst_i = 1'b0;
        #1;
        check_output("abort_rsp_valid", 64'(rsp_valid_o), 64'd0);
        check_output("abort_start", 64'(start_o), 64'd0);
        check_output("abort_a", 64'(a_bo), 64'd0);
        check_output("abort_y", y_bo, 64'd0);
        check_output("abort_req_ready_busy", 64'(req_ready_o), 64'd0);
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        saw = 1'b0;
        k = 0;
        while (u_state != 0 && k < 200) begin
            @(negedge clk);
            if (rsp_valid_o) saw = 1'b1;
            k++;
        end
        check_output("abort_no_rsp", 64'(saw), 64'd0);
        @(negedge clk);
        check_output("abort_idle_ready", 64'(req_ready_o), 64'd1);
        @(posedge clk);
        #1;

        rand_rdy = 1'b1;
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            issue(32'($urandom_range(0, 255)), 32'($urandom_range(0, 255)), 0,
                  int'($urandom_range(1, 20)), 1'b1, 1'b1, w);
        end
        k = 0;
        while (exp_q.size() != 0 && k < 5000) begin
            @(posedge clk);
            #1;
            k++;
        end
        rand_rdy = 1'b0;
        rsp_ready_i = 1'b1;
        check_output("drain_queue", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clk);
        check_output("start_count", 64'(starts), 64'(accepted));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
